// File: rtl/lif_drv_pkg.sv
// Shared types and constants for the LIF neuron stream driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lif_drv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_W = 2'd1,
        ST_LOAD_I = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    localparam int N_STAGES_DEF = 5;

    // Bytes per operand vector: the neuron takes 2**n_stages bits per vector.
    function automatic int bytes_for(input int n_stages);
        return (2 ** n_stages) / 8;
    endfunction

    localparam int BYTES = bytes_for(N_STAGES_DEF);

    // All-ones marker for "no spike seen"; modules slice the low RUN_W bits.
    localparam logic [31:0] NO_SPIKE = '1;

endpackage

// File: rtl/lif_drv_serializer.sv
// Holds one operand vector and emits it a byte at a time, MSB byte first.
// Latency: byte_dat valid the cycle after load; each advance exposes the next byte.
// Backpressure: none; the owner steps it with advance once per byte cycle.
//
// Ports: load/vec capture a new vector (load wins over advance), advance
// shifts one byte out, byte_dat is the current byte (zero once drained),
// last flags that the current byte is the final one of the vector.
module lif_drv_serializer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             advance,
    input  logic [WIDTH-1:0] vec,
    output logic [7:0]       byte_dat,
    output logic             last
);
    localparam int BYTES = WIDTH / 8;
    localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    idx;

    // Zero fill on shift means the port returns to 0 by itself after the
    // final byte, so the top byte can drive the neuron directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            idx   <= '0;
        end else if (load) begin
            shreg <= vec;
            idx   <= '0;
        end else if (advance) begin
            shreg <= shreg << 8;
            idx   <= idx + CW'(1);
        end
    end

    assign byte_dat = shreg[WIDTH-1 -: 8];
    assign last     = (idx == CW'(BYTES - 1));

endmodule

// File: rtl/lif_stream_driver.sv
// Serialises weight/input vectors into the LIF neuron, then runs it and counts spikes.
// Latency: first byte one cycle after start; done one cycle after the last busy cycle.
// Backpressure: none; start is ignored while busy, operands are latched at start.
//
// Ports: start/load_weights/weights_i/inputs_i/run_cycles from the host;
// data_out/sel_weights/run_en drive the neuron load pins, spike_in is its
// spike output; busy/done/spike_count/first_spike report back to the host.
// Build option: LIF_DRV_STOP_ON_SPIKE_EN ends RUN at the first recorded spike.
module lif_stream_driver
    import lif_drv_pkg::*;
#(
    parameter int N_STAGES = 5,
    parameter int RUN_W    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    load_weights,
    input  logic [2**N_STAGES-1:0]  weights_i,
    input  logic [2**N_STAGES-1:0]  inputs_i,
    input  logic [RUN_W-1:0]        run_cycles,
    output logic [7:0]              data_out,
    output logic                    sel_weights,
    output logic                    run_en,
    input  logic                    spike_in,
    output logic                    busy,
    output logic                    done,
    output logic [RUN_W-1:0]        spike_count,
    output logic [RUN_W-1:0]        first_spike
);
    localparam int INPUTS = 2 ** N_STAGES;
    localparam logic [RUN_W-1:0] NO_SPIKE_W = NO_SPIKE[RUN_W-1:0];

`ifdef LIF_DRV_STOP_ON_SPIKE_EN
    localparam logic STOP_ON_SPIKE = 1'b1;
`else
    localparam logic STOP_ON_SPIKE = 1'b0;
`endif

    state_t            state, state_nxt;
    logic [INPUTS-1:0] inputs_q;
    logic [RUN_W-1:0]  run_q;
    logic [RUN_W-1:0]  run_cnt;
    logic              run_last;
    logic              accept;

    logic              ser_load, ser_adv, ser_last;
    logic [INPUTS-1:0] ser_vec;

    logic              sel_d, run_en_d, busy_d, done_d;

    assign accept   = (state == ST_IDLE) && start;
    assign run_last = (run_cnt == run_q - RUN_W'(1));

    // Weights go straight into the serializer at start; the input vector is
    // held here until the weight bytes have drained.
    lif_drv_serializer #(.WIDTH(INPUTS)) u_ser (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ser_load),
        .advance  (ser_adv),
        .vec      (ser_vec),
        .byte_dat (data_out),
        .last     (ser_last)
    );

    always_comb begin
        ser_load = accept || ((state == ST_LOAD_W) && ser_last);
        ser_vec  = inputs_q;
        if (state == ST_IDLE)
            ser_vec = load_weights ? weights_i : inputs_i;
        ser_adv  = ((state == ST_LOAD_W) || (state == ST_LOAD_I)) && !ser_load;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = load_weights ? ST_LOAD_W : ST_LOAD_I;
            ST_LOAD_W: if (ser_last) state_nxt = ST_LOAD_I;
            ST_LOAD_I: if (ser_last) state_nxt = (run_q != '0) ? ST_RUN : ST_IDLE;
            ST_RUN:    if (run_last || (STOP_ON_SPIKE && spike_in)) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Output logic, decoded from the next state so the pins are registered.
    always_comb begin
        sel_d    = (state_nxt == ST_LOAD_W);
        run_en_d = !((state_nxt == ST_LOAD_W) || (state_nxt == ST_LOAD_I));
        busy_d   = (state_nxt != ST_IDLE);
        done_d   = (state != ST_IDLE) && (state_nxt == ST_IDLE);
    end

    // first_spike doubles as the "seen" flag: run indices never reach all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_weights <= 1'b0;
            run_en      <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            spike_count <= '0;
            first_spike <= NO_SPIKE_W;
            inputs_q    <= '0;
            run_q       <= '0;
            run_cnt     <= '0;
        end else begin
            sel_weights <= sel_d;
            run_en      <= run_en_d;
            busy        <= busy_d;
            done        <= done_d;
            if (accept) begin
                inputs_q    <= inputs_i;
                run_q       <= run_cycles;
                run_cnt     <= '0;
                spike_count <= '0;
                first_spike <= NO_SPIKE_W;
            end else if (state == ST_RUN) begin
                run_cnt <= run_cnt + RUN_W'(1);
                if (spike_in) begin
                    spike_count <= spike_count + RUN_W'(1);
                    if (first_spike == NO_SPIKE_W)
                        first_spike <= run_cnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_lif_stream_driver.sv
// Bench for lif_stream_driver: vector table plus multi-cycle corner sequences.
module tb_lif_stream_driver;
    localparam int N_STAGES = 5;
    localparam int RUN_W    = 8;
    localparam int BYTES    = 4;

    logic        clk = 1'b0;
    logic        clk_en = 1'b1;
    logic        rst_n;
    logic        start;
    logic        load_weights;
    logic [31:0] weights_i;
    logic [31:0] inputs_i;
    logic [7:0]  run_cycles;
    logic [7:0]  data_out;
    logic        sel_weights;
    logic        run_en;
    logic        spike_in;
    logic        busy;
    logic        done;
    logic [7:0]  spike_count;
    logic [7:0]  first_spike;

    lif_stream_driver #(.N_STAGES(N_STAGES), .RUN_W(RUN_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .load_weights (load_weights),
        .weights_i    (weights_i),
        .inputs_i     (inputs_i),
        .run_cycles   (run_cycles),
        .data_out     (data_out),
        .sel_weights  (sel_weights),
        .run_en       (run_en),
        .spike_in     (spike_in),
        .busy         (busy),
        .done         (done),
        .spike_count  (spike_count),
        .first_spike  (first_spike)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    typedef struct {
        logic        lw;
        logic [31:0] w;
        logic [31:0] i;
        logic [7:0]  rc;
        logic [31:0] mask;     // spike_in per RUN cycle index
        logic [7:0]  exp_sc;
        logic [7:0]  exp_fs;
        int          exp_busy;
    } vec_t;

    typedef struct {
        logic       sel;
        logic [7:0] dat;
    } byte_t;

    vec_t  tbl[7];
    byte_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " data_out"},    32'(data_out), 32'h0);
        check({tag, " sel_weights"}, 32'(sel_weights), 32'h0);
        check({tag, " run_en"},      32'(run_en), 32'h1);
        check({tag, " busy"},        32'(busy), 32'h0);
        check({tag, " done"},        32'(done), 32'h0);
        check({tag, " spike_count"}, 32'(spike_count), 32'h0);
        check({tag, " first_spike"}, 32'(first_spike), 32'hFF);
    endtask

    // Called at a negedge with the DUT idle (or in its done cycle); pulses
    // start for one cycle and queues the bytes the neuron should receive.
    task automatic start_txn(input vec_t v);
        logic [31:0] w, x;
        w = v.w;
        x = v.i;
        load_weights = v.lw;
        weights_i    = v.w;
        inputs_i     = v.i;
        run_cycles   = v.rc;
        start        = 1'b1;
        if (v.lw)
            for (int b = BYTES - 1; b >= 0; b--) exp_q.push_back('{1'b1, w[b*8 +: 8]});
        for (int b = BYTES - 1; b >= 0; b--) exp_q.push_back('{1'b0, x[b*8 +: 8]});
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitors one transaction from the first cycle after start until done.
    // Returns at the negedge of the done cycle.
    task automatic wait_txn(input vec_t v, input bit disturb, input string name);
        int    cyc, busy_n, run_idx;
        bit    got_done;
        byte_t e;
        cyc = 1; busy_n = 0; run_idx = 0; got_done = 0;
        while (cyc <= 200 && !got_done) begin
            if (done) begin
                got_done = 1;
            end else begin
                if (busy) busy_n++;
                if (busy && !run_en) begin
                    if (exp_q.size() == 0) begin
                        check({name, " extra byte"}, 32'(data_out), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check({name, " byte"}, {23'b0, sel_weights, data_out}, {23'b0, e.sel, e.dat});
                    end
                end
                if (busy && run_en) begin
                    check({name, " run data_out"}, {23'b0, sel_weights, data_out}, 32'h0);
                    spike_in = v.mask[run_idx];
                    run_idx++;
                end else begin
                    spike_in = 1'b0;
                end
                if (disturb) begin
                    start        = busy ? 1'($urandom_range(0, 1)) : 1'b0;
                    weights_i    = $urandom;
                    inputs_i     = $urandom;
                    run_cycles   = 8'($urandom);
                    load_weights = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
                cyc++;
            end
        end
        spike_in = 1'b0;
        if (disturb) start = 1'b0;
        check({name, " done seen"}, 32'(got_done), 32'h1);
        if (got_done) begin
            check({name, " done cycle"},  32'(cyc), 32'(v.exp_busy + 1));
            check({name, " busy cycles"}, 32'(busy_n), 32'(v.exp_busy));
            check({name, " busy at done"}, 32'(busy), 32'h0);
            check({name, " spike_count"}, 32'(spike_count), 32'(v.exp_sc));
            check({name, " first_spike"}, 32'(first_spike), 32'(v.exp_fs));
            check({name, " bytes left"},  32'(exp_q.size()), 32'h0);
        end
        exp_q.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        load_weights = 1'b0;
        weights_i = '0;
        inputs_i = '0;
        run_cycles = '0;
        spike_in = 1'b0;

        //         lw   weights       inputs        rc    spike mask  sc    fs     busy
        tbl[0] = '{1'b1, 32'hA1B2C3D4, 32'h11223344, 8'd0, 32'h0,      8'd0, 8'hFF, 8};
        tbl[1] = '{1'b0, 32'h0,        32'hDEADBEEF, 8'd0, 32'h0,      8'd0, 8'hFF, 4};
        tbl[2] = '{1'b1, 32'h01234567, 32'h89ABCDEF, 8'd3, 32'hFFFFFFFF, 8'd3, 8'd0, 11};
`ifdef LIF_DRV_STOP_ON_SPIKE_EN
        tbl[3] = '{1'b1, 32'hCAFEF00D, 32'h0F0F0F0F, 8'd5, 32'h4,      8'd1, 8'd2,  11};
        tbl[4] = '{1'b0, 32'h0,        32'h80000001, 8'd6, 32'h2A,     8'd1, 8'd1,  6};
        tbl[6] = '{1'b0, 32'h0,        32'h00FF00FF, 8'd1, 32'h1,      8'd1, 8'd0,  5};
`else
        tbl[3] = '{1'b1, 32'hCAFEF00D, 32'h0F0F0F0F, 8'd5, 32'h4,      8'd1, 8'd2,  13};
        tbl[4] = '{1'b0, 32'h0,        32'h80000001, 8'd6, 32'h2A,     8'd3, 8'd1,  10};
        tbl[6] = '{1'b0, 32'h0,        32'h00FF00FF, 8'd1, 32'h1,      8'd1, 8'd0,  5};
`endif
        tbl[5] = '{1'b1, 32'h5A5AA5A5, 32'h12345678, 8'd4, 32'h0,      8'd0, 8'hFF, 12};

        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 7; t++) begin
            start_txn(tbl[t]);
            wait_txn(tbl[t], 1'b0, $sformatf("vec%0d", t));
            @(negedge clk);
            check($sformatf("vec%0d done pulse", t), 32'(done), 32'h0);
        end

        // start hammered and operands scrambled while busy
        start_txn(tbl[3]);
        wait_txn(tbl[3], 1'b1, "disturb");
        @(negedge clk);
        check("disturb single done", {30'b0, busy, done}, 32'h0);

        // back-to-back: second start issued in the done cycle of the first
        start_txn(tbl[0]);
        wait_txn(tbl[0], 1'b0, "b2b first");
        start_txn(tbl[1]);
        wait_txn(tbl[1], 1'b0, "b2b second");
        @(negedge clk);

        // reset mid-RUN with the clock stopped
        begin
            vec_t r;
            int   guard;
            r = '{1'b1, 32'h11111111, 32'h22222222, 8'd20, 32'h0, 8'd0, 8'hFF, 28};
            start_txn(r);
            exp_q.delete();
            guard = 0;
            while (!(busy && run_en) && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            check("reach RUN", 32'(busy && run_en), 32'h1);
            spike_in = 1'b1;
            repeat (2) @(negedge clk);
            spike_in = 1'b0;
            check("pre-reset spike_count", 32'(spike_count), 32'h2);
            clk_en = 1'b0;
            #2;
            rst_n = 1'b0;
            #2;
            check_reset_vals("async reset");
            #10;
            rst_n = 1'b1;
            #3;
            clk_en = 1'b1;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                check($sformatf("post-reset idle %0d", k), {30'b0, busy, done}, 32'h0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
